sum_accum: RTL and testbench
============================

// Module: sum_accum
// PURPOSE
//   Downstream consumer of the 4-input pipelined adder tree. Accepts the
//   stream of per-cycle sums, accumulates blocks of blk_len beats and emits
//   one wide block total with a valid/ready handshake. Applies backpressure
//   upstream while a result is waiting to be taken.
// PARAMETERS
//   DSIZE  64  width of input sum (matches adder tree DSIZE)
//   ACC_W  72  accumulator/result width; must be >= DSIZE
//   CNT_W  8   width of block-length and beat counters
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   in_valid   in   1      in_data valid this cycle
//   in_ready   out  1      block can accept a beat this cycle
//   in_data    in   DSIZE  unsigned sum from adder tree
//   blk_len    in   CNT_W  beats per block; sampled on first beat; 0 means 1
//   flush      in   1      close the current block early
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  ACC_W  block total, unsigned
//   out_count  out  CNT_W  number of beats in this block
//   out_ovf    out  1      carry out of ACC_W occurred during this block
// BEHAVIOUR
//   - Reset: state IDLE; out_valid=0, out_data=0, out_count=0, out_ovf=0;
//     internal acc/cnt/len=0. in_ready=1 after reset release.
//   - Beat accepted = in_valid & in_ready. All regs update on posedge clk.
//   - States:
//     IDLE : in_ready=1. On beat: acc<=zext(in_data), cnt<=1,
//            len<=(blk_len==0)?1:blk_len, ovf<=0. Go HOLD if len_eff==1 or
//            flush, else ACCUM. flush without a beat is ignored.
//     ACCUM: in_ready=1. On beat: acc<=acc+zext(in_data) mod 2^ACC_W,
//            cnt<=cnt+1, ovf|=carry. Go HOLD if cnt+1==len or flush.
//            flush without a beat: go HOLD with current acc/cnt.
//            blk_len changes after the first beat have no effect.
//     HOLD : in_ready=0; out_valid=1; out_data=acc, out_count=cnt,
//            out_ovf=ovf, all stable until accepted. On out_ready: go IDLE,
//            out_valid<=0 next cycle.
//   - Latency: beat that closes the block in cycle T -> out_valid=1 at T+1.
//     One idle bubble on input per block (HOLD always lasts >= 1 cycle).
//   - out_ready while out_valid=0 has no effect. out_data/out_count/
//     out_ovf keep last value after acceptance (don't-care when !out_valid).
//   - Arithmetic: in_data zero-extended to ACC_W; wrap modulo 2^ACC_W;
//     carry out of bit ACC_W-1 sets sticky out_ovf for the block.
//     Defaults (ACC_W=72, max 255 beats) never overflow.
//   - Reset asserted mid-block or in HOLD: block discarded, no output.
// TESTING
//   1 blk_len=4, beats 1,2,3,4 back-to-back, out_ready=1 -> out_valid one
//     cycle after beat 4, out_data=10, out_count=4, out_ovf=0; in_ready=0
//     for exactly 1 cycle.
//   2 blk_len=2, beats 5,7, out_ready=0 for 3 cycles then 1 -> out_data=12
//     held stable 4 cycles, in_ready=0 throughout, beats offered are not
//     taken; next block starts the cycle after acceptance.
//   3 blk_len=8, beats 10,20,30 with flush on 3rd beat -> out_data=60,
//     out_count=3; then flush alone in IDLE -> no output.
//   4 blk_len=0, single beat 0xFF -> out_data=0xFF, out_count=1.
//   5 ACC_W=DSIZE=64, blk_len=2, beats 2^64-1 twice -> out_data=2^64-2,
//     out_ovf=1; following block 1,1 -> out_ovf=0.
//   6 rst_n low after 2 of 4 beats, release, send blk_len=2 beats 3,4 ->
//     out_data=7, out_count=2 (no residue from aborted block).

Source files
------------

// File: rtl/sum_accum_if.sv
// Stream handshake between the adder tree, the block accumulator and its consumer.
// The bundle carries the input beat channel and the block result channel.
interface sum_accum_if #(
  parameter int unsigned DSIZE = 64,
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_data;
  logic [CNT_W-1:0] blk_len;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, blk_len, flush, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, blk_len, flush, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accum.sv
// Block accumulator: sums blk_len beats of adder-tree output and presents one
// wide total per block, stalling the input while the total waits downstream.
module sum_accum #(
  parameter int unsigned DSIZE = 64,
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sum_accum_if.slave  bus
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               out_ovf_q;

  logic               beat;
  logic [SUM_W-1:0]   sum_w;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   len_eff;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    beat    = bus.in_valid & (state_q != HOLD);
    sum_w   = {1'b0, acc_q} + SUM_W'(bus.in_data);
    cnt_inc = cnt_q + CNT_W'(1);
    len_eff = (bus.blk_len == '0) ? CNT_W'(1) : bus.blk_len;

    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d = ACC_W'(bus.in_data);
          cnt_d = CNT_W'(1);
          len_d = len_eff;
          ovf_d = 1'b0;
          state_d = (len_eff == CNT_W'(1) || bus.flush) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = sum_w[ACC_W-1:0];
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum_w[ACC_W];
          if (cnt_inc == len_q || bus.flush) begin
            state_d = HOLD;
          end
        end else if (bus.flush) begin
          // Early close without a beat keeps the partial total as-is
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
      // Result is captured on entry to HOLD and then left untouched
      if (state_d == HOLD && state_q != HOLD) begin
        out_data_q  <= acc_d;
        out_count_q <= cnt_d;
        out_ovf_q   <= ovf_d;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sum_accum.sv
// Scoreboard bench: two accumulators (72-bit and 64-bit totals) share one stimulus
// stream; expected block totals come from exact wide arithmetic on accepted beats.
module tb_sum_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum_accum_if #(.DSIZE(64), .ACC_W(72), .CNT_W(8)) bus72 ();
  sum_accum_if #(.DSIZE(64), .ACC_W(64), .CNT_W(8)) bus64 ();

  sum_accum #(.DSIZE(64), .ACC_W(72), .CNT_W(8)) u72 (.clk(clk), .rst_n(rst_n), .bus(bus72));
  sum_accum #(.DSIZE(64), .ACC_W(64), .CNT_W(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct packed {
    logic [71:0] d72;
    logic        o72;
    logic [63:0] d64;
    logic        o64;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: exact running total of the open block
  bit           hold_m = 1'b0;
  bit           open_m = 1'b0;
  int           cnt_m  = 0;
  int           len_m  = 0;
  logic [127:0] tot_m  = '0;

  logic [71:0] last_d72 = '0;
  logic [63:0] last_d64 = '0;
  logic        last_o64 = 1'b0;
  logic [7:0]  last_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic close_blk();
    exp_t e;
    e.d72 = tot_m[71:0];
    e.o72 = |tot_m[127:72];
    e.d64 = tot_m[63:0];
    e.o64 = |tot_m[127:64];
    e.cnt = 8'(cnt_m);
    q.push_back(e);
    open_m = 1'b0;
    hold_m = 1'b1;
  endtask

  task automatic set_inputs(input bit v, input logic [63:0] d, input logic [7:0] len,
                            input bit fl, input bit ordy);
    bus72.in_valid = v;  bus64.in_valid = v;
    bus72.in_data  = d;  bus64.in_data  = d;
    bus72.blk_len  = len; bus64.blk_len = len;
    bus72.flush    = fl; bus64.flush    = fl;
    bus72.out_ready = ordy; bus64.out_ready = ordy;
  endtask

  // One clock cycle: drive, check handshake state against the model, advance the model
  task automatic cyc(input bit v, input logic [63:0] d, input logic [7:0] len,
                     input bit fl, input bit ordy);
    @(posedge clk);
    #1;
    set_inputs(v, d, len, fl, ordy);
    chk("in_ready72",  128'(bus72.in_ready),  128'(!hold_m));
    chk("in_ready64",  128'(bus64.in_ready),  128'(!hold_m));
    chk("out_valid72", 128'(bus72.out_valid), 128'(hold_m));
    chk("out_valid64", 128'(bus64.out_valid), 128'(hold_m));
    if (!hold_m) begin
      if (v) begin
        if (!open_m) begin
          open_m = 1'b1;
          len_m  = (len == 8'd0) ? 1 : int'(len);
          cnt_m  = 0;
          tot_m  = '0;
        end
        tot_m = tot_m + 128'(d);
        cnt_m++;
        if (cnt_m == len_m || fl) close_blk();
      end else if (fl && open_m) begin
        close_blk();
      end
    end else if (ordy) begin
      hold_m = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid72", 128'(bus72.out_valid), 128'd0);
    chk("rst_out_valid64", 128'(bus64.out_valid), 128'd0);
    chk("rst_in_ready72",  128'(bus72.in_ready),  128'd1);
    chk("rst_out_data72",  128'(bus72.out_data),  128'd0);
    chk("rst_out_count72", 128'(bus72.out_count), 128'd0);
    chk("rst_out_ovf64",   128'(bus64.out_ovf),   128'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_inputs(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    hold_m = 1'b0;
    open_m = 1'b0;
    q.delete();
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: any presented result must match the head of the queue until taken
  always @(negedge clk) begin
    if (rst_n && bus72.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 128'd1, 128'd0);
      end else begin
        chk("out_data72",  128'(bus72.out_data),  128'(q[0].d72));
        chk("out_ovf72",   128'(bus72.out_ovf),   128'(q[0].o72));
        chk("out_count72", 128'(bus72.out_count), 128'(q[0].cnt));
        chk("out_data64",  128'(bus64.out_data),  128'(q[0].d64));
        chk("out_ovf64",   128'(bus64.out_ovf),   128'(q[0].o64));
        chk("out_count64", 128'(bus64.out_count), 128'(q[0].cnt));
        if (bus72.out_ready) begin
          last_d72 = bus72.out_data;
          last_d64 = bus64.out_data;
          last_o64 = bus64.out_ovf;
          last_cnt = bus72.out_count;
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] d;
    rst_n = 1'b0;
    set_inputs(1'b0, 64'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;

    // Four back-to-back beats, immediate acceptance
    cyc(1, 64'd1, 8'd4, 0, 1); cyc(1, 64'd2, 8'd4, 0, 1);
    cyc(1, 64'd3, 8'd4, 0, 1); cyc(1, 64'd4, 8'd4, 0, 1);
    idle(2);
    chk("t1_data", 128'(last_d72), 128'd10);
    chk("t1_count", 128'(last_cnt), 128'd4);
    chk("t1_ovf", 128'(last_o64), 128'd0);

    // Result held under backpressure; offered beats ignored until accepted
    cyc(1, 64'd5, 8'd2, 0, 0); cyc(1, 64'd7, 8'd2, 0, 0);
    repeat (3) cyc(1, 64'd9, 8'd2, 0, 0);
    cyc(1, 64'd9, 8'd2, 0, 1);
    cyc(1, 64'd11, 8'd1, 0, 1);
    chk("t2_data", 128'(last_d72), 128'd12);
    chk("t2_count", 128'(last_cnt), 128'd2);
    idle(2);
    chk("t2_next", 128'(last_d72), 128'd11);

    // Early close by flush, then flush alone in idle
    cyc(1, 64'd10, 8'd8, 0, 1); cyc(1, 64'd20, 8'd8, 0, 1); cyc(1, 64'd30, 8'd8, 1, 1);
    idle(2);
    chk("t3_data", 128'(last_d72), 128'd60);
    chk("t3_count", 128'(last_cnt), 128'd3);
    cyc(0, 64'd0, 8'd8, 1, 1);
    idle(2);

    // blk_len of zero means a single beat
    cyc(1, 64'hFF, 8'd0, 0, 1);
    idle(2);
    chk("t4_data", 128'(last_d72), 128'hFF);
    chk("t4_count", 128'(last_cnt), 128'd1);

    // Carry out of the 64-bit accumulator, then a clean block
    cyc(1, '1, 8'd2, 0, 1); cyc(1, '1, 8'd2, 0, 1);
    idle(2);
    chk("t5_data64", 128'(last_d64), 128'hFFFF_FFFF_FFFF_FFFE);
    chk("t5_ovf64", 128'(last_o64), 128'd1);
    chk("t5_data72", 128'(last_d72), 128'h1_FFFF_FFFF_FFFF_FFFE);
    cyc(1, 64'd1, 8'd2, 0, 1); cyc(1, 64'd1, 8'd2, 0, 1);
    idle(2);
    chk("t5b_ovf64", 128'(last_o64), 128'd0);
    chk("t5b_data64", 128'(last_d64), 128'd2);

    // Reset mid-block leaves no residue
    cyc(1, 64'd100, 8'd4, 0, 1); cyc(1, 64'd200, 8'd4, 0, 1);
    do_reset();
    cyc(1, 64'd3, 8'd2, 0, 1); cyc(1, 64'd4, 8'd2, 0, 1);
    idle(2);
    chk("t6_data", 128'(last_d72), 128'd7);
    chk("t6_count", 128'(last_cnt), 128'd2);

    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      case ($urandom_range(0, 3))
        0:       d = '1 - 64'($urandom_range(0, 3));
        1:       d = {$urandom, $urandom};
        default: d = 64'($urandom_range(0, 1000));
      endcase
      cyc($urandom_range(0, 9) < 7, d, 8'($urandom_range(0, 6)),
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
    end

    idle(4);
    chk("drain_empty", 128'(q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
